led_color_sequencer: RTL and testbench



---
 rtl/led_color_sequencer.sv | 125 ++++++++++++
 tb/tb_led_color_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/led_color_sequencer.sv
// led_color_sequencer: plays four register-held colors as a repeating RGB LED pattern.
// Ports: WBs_CLK_i clock; WBs_RST_i sync active-high reset; enable_i run enable;
//        color0..3 step colors (bit2=R, bit1=G, bit0=B); duration0..3 step ticks (0 = skip);
//        led_r_o/led_g_o/led_b_o LED drives; step_o shown step; running_o high in RUN;
//        step_done_o step-complete pulse; wrap_o pulse when the sequence returns to a lower/equal step.
module led_color_sequencer #(
    parameter int PRESCALE = 12000,
    parameter int PS_WIDTH = 16
) (
    input  logic        WBs_CLK_i,
    input  logic        WBs_RST_i,
    input  logic        enable_i,
    input  logic [2:0]  color0,
    input  logic [2:0]  color1,
    input  logic [2:0]  color2,
    input  logic [2:0]  color3,
    input  logic [11:0] duration0,
    input  logic [11:0] duration1,
    input  logic [11:0] duration2,
    input  logic [11:0] duration3,
    output logic        led_r_o,
    output logic        led_g_o,
    output logic        led_b_o,
    output logic [1:0]  step_o,
    output logic        running_o,
    output logic        step_done_o,
    output logic        wrap_o
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                r_state, w_state_n;
    logic [1:0]            r_step, w_step_n;
    logic [2:0]            r_color, w_color_n;
    logic [11:0]           r_rem, w_rem_n;
    logic [PS_WIDTH-1:0]   r_ps, w_ps_n;
    logic                  r_done, w_done_n, r_wrap, w_wrap_n;
    logic [2:0]            w_col [4];
    logic [11:0]           w_dur [4];
    logic [3:0]            w_nz;
    logic [2:0]            w_first, w_next;
    logic                  w_tick, w_last;

    // Returns {found, index} of the first nonzero-duration step at or after start, modulo 4.
    function automatic logic [2:0] f_search(input logic [1:0] start, input logic [3:0] nz);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int j = 3; j >= 0; j--) begin
            idx = start + 2'(j);
            if (nz[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_col   = '{color0, color1, color2, color3};
    assign w_dur   = '{duration0, duration1, duration2, duration3};
    assign w_nz    = {|duration3, |duration2, |duration1, |duration0};
    assign w_first = f_search(2'd0, w_nz);
    assign w_next  = f_search(r_step + 2'd1, w_nz);
    assign w_tick  = r_ps == PS_WIDTH'(PRESCALE - 1);
    assign w_last  = w_tick && r_rem == 12'd1;

    always_comb begin
        w_state_n = r_state;
        w_step_n  = r_step;
        w_color_n = r_color;
        w_rem_n   = r_rem;
        w_ps_n    = r_ps;
        w_done_n  = 1'b0;
        w_wrap_n  = 1'b0;
        if (r_state == IDLE) begin
            if (enable_i && w_first[2]) begin
                w_state_n = RUN;
                w_step_n  = w_first[1:0];
                w_color_n = w_col[w_first[1:0]];
                w_rem_n   = w_dur[w_first[1:0]];
                w_ps_n    = '0;
            end
        end else if (!enable_i || (w_last && !w_next[2])) begin
            // Enable drop wins over a coinciding step end and emits no pulse.
            w_state_n = IDLE;
            w_step_n  = '0;
            w_color_n = '0;
            w_rem_n   = '0;
            w_ps_n    = '0;
            w_done_n  = enable_i;
        end else if (w_last) begin
            w_done_n  = 1'b1;
            w_wrap_n  = w_next[1:0] <= r_step;
            w_step_n  = w_next[1:0];
            w_color_n = w_col[w_next[1:0]];
            w_rem_n   = w_dur[w_next[1:0]];
            w_ps_n    = '0;
        end else begin
            w_ps_n    = w_tick ? '0 : r_ps + PS_WIDTH'(1);
            w_rem_n   = w_tick ? r_rem - 12'd1 : r_rem;
        end
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_color <= '0;
            r_rem   <= '0;
            r_ps    <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_step  <= w_step_n;
            r_color <= w_color_n;
            r_rem   <= w_rem_n;
            r_ps    <= w_ps_n;
            r_done  <= w_done_n;
            r_wrap  <= w_wrap_n;
        end
    end

    // r_color is cleared whenever RUN is left, so the LEDs are dark outside RUN.
    assign {led_r_o, led_g_o, led_b_o} = r_color;
    assign step_o      = r_step;
    assign running_o   = r_state == RUN;
    assign step_done_o = r_done;
    assign wrap_o      = r_wrap;
endmodule

// File: tb/tb_led_color_sequencer.sv
// tb_led_color_sequencer: checks two sequencer instances (PRESCALE 4 and 1) against a cycle-count model.
module tb_led_color_sequencer;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [2:0]  col [4];
    logic [11:0] dur [4];
    logic        r4, g4, b4, run4, done4, wrap4;
    logic        r1, g1, b1, run1, done1, wrap1;
    logic [1:0]  s4, s1;
    int          n_checks = 0;
    int          n_pass = 0;

    typedef struct packed {
        logic        run;
        logic [1:0]  step;
        logic [2:0]  col;
        logic [31:0] left;
        logic        done;
        logic        wrap;
    } mst_t;
    mst_t m4 = '0;
    mst_t m1 = '0;

    always #5 clk = ~clk;

    led_color_sequencer #(.PRESCALE(4), .PS_WIDTH(16)) dut4 (
        .WBs_CLK_i(clk), .WBs_RST_i(rst), .enable_i(en),
        .color0(col[0]), .color1(col[1]), .color2(col[2]), .color3(col[3]),
        .duration0(dur[0]), .duration1(dur[1]), .duration2(dur[2]), .duration3(dur[3]),
        .led_r_o(r4), .led_g_o(g4), .led_b_o(b4), .step_o(s4),
        .running_o(run4), .step_done_o(done4), .wrap_o(wrap4));

    led_color_sequencer #(.PRESCALE(1), .PS_WIDTH(16)) dut1 (
        .WBs_CLK_i(clk), .WBs_RST_i(rst), .enable_i(en),
        .color0(col[0]), .color1(col[1]), .color2(col[2]), .color3(col[3]),
        .duration0(dur[0]), .duration1(dur[1]), .duration2(dur[2]), .duration3(dur[3]),
        .led_r_o(r1), .led_g_o(g1), .led_b_o(b1), .step_o(s1),
        .running_o(run1), .step_done_o(done1), .wrap_o(wrap1));

    function automatic int first(input int s);
        for (int o = 0; o < 4; o++) if (dur[(s + o) % 4] != 0) return (s + o) % 4;
        return -1;
    endfunction

    // Model: each step simply lasts duration*p cycles counted down as one number.
    function automatic mst_t advance(input mst_t c, input int p);
        mst_t n = c;
        int   k;
        n.done = 1'b0;
        n.wrap = 1'b0;
        k = first(c.run ? int'(c.step) + 1 : 0);
        if (rst || (c.run && !en)) n = '0;
        else if (!c.run) begin
            if (en && k >= 0) begin
                n.run = 1'b1; n.step = k[1:0]; n.col = col[k]; n.left = dur[k] * p;
            end
        end else if (c.left == 1) begin
            n.done = 1'b1;
            if (k < 0) begin
                n.run = 1'b0; n.step = '0; n.col = '0; n.left = 0;
            end else begin
                n.wrap = k <= int'(c.step);
                n.step = k[1:0]; n.col = col[k]; n.left = dur[k] * p;
            end
        end else n.left = c.left - 1;
        return n;
    endfunction

    function automatic logic [7:0] expv(input mst_t m);
        return {m.col, m.step, m.run, m.done, m.wrap};
    endfunction

    function automatic logic [7:0] o4();
        return {r4, g4, b4, s4, run4, done4, wrap4};
    endfunction

    function automatic logic [7:0] o1();
        return {r1, g1, b1, s1, run1, done1, wrap1};
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b exp=%b (rgb,step,run,done,wrap)", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        m4 <= advance(m4, 4);
        m1 <= advance(m1, 1);
    end

    always @(negedge clk) begin
        chk("model_p4", o4(), expv(m4));
        chk("model_p1", o1(), expv(m1));
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        col = '{3'd1, 3'd2, 3'd4, 3'd7};
        dur = '{12'd2, 12'd0, 12'd3, 12'd0};
        tick(2);
        chk("reset", o4(), 8'b000_00_0_0_0);
        rst = 1'b0;
        tick(3);
        chk("idle_no_enable", o4(), 8'b000_00_0_0_0);
        en = 1'b1;
        tick(1);
        chk("basic_c1", o4(), 8'b001_00_1_0_0);
        tick(8);
        chk("basic_c9", o4(), 8'b100_10_1_1_0);
        tick(12);
        chk("basic_c21_wrap", o4(), 8'b001_00_1_1_1);
        tick(24);
        en = 1'b0;
        tick(2);
        en = 1'b1;
        tick(1);
        chk("mid_c1", o4(), 8'b001_00_1_0_0);
        tick(2);
        col[0] = 3'd6;
        dur[0] = 12'd5;
        tick(5);
        chk("mid_c8_old", o4(), 8'b001_00_1_0_0);
        tick(1);
        chk("mid_c9", o4(), 8'b100_10_1_1_0);
        tick(12);
        chk("mid_c21_new", o4(), 8'b110_00_1_1_1);
        tick(19);
        chk("mid_c40", o4(), 8'b110_00_1_0_0);
        tick(1);
        chk("mid_c41", o4(), 8'b100_10_1_1_0);
        col[0] = 3'd1;
        dur[0] = 12'd2;
        tick(4);
        en = 1'b0;
        tick(1);
        chk("drop_enable", o4(), 8'b000_00_0_0_0);
        en = 1'b1;
        tick(1);
        chk("reenable", o4(), 8'b001_00_1_0_0);
        dur = '{12'd0, 12'd0, 12'd0, 12'd0};
        tick(30);
        chk("all_zero", o4(), 8'b000_00_0_0_0);
        dur[1] = 12'd1;
        tick(1);
        chk("single_enter", o4(), 8'b010_01_1_0_0);
        tick(4);
        chk("single_wrap", o4(), 8'b010_01_1_1_1);
        dur = '{12'd2, 12'd0, 12'd3, 12'd0};
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("reset_mid_run", o4(), 8'b000_00_0_0_0);
        rst = 1'b0;
        tick(1);
        chk("reset_restart", o4(), 8'b001_00_1_0_0);
        en = 1'b0;
        tick(1);
        dur = '{12'd4095, 12'd1, 12'd1, 12'd1};
        en = 1'b1;
        tick(1);
        chk("p1_c1", o1(), 8'b001_00_1_0_0);
        tick(4094);
        chk("p1_c4095", o1(), 8'b001_00_1_0_0);
        tick(1);
        chk("p1_c4096", o1(), 8'b010_01_1_1_0);
        tick(1);
        chk("p1_c4097", o1(), 8'b100_10_1_1_0);
        tick(1);
        chk("p1_c4098", o1(), 8'b111_11_1_1_0);
        tick(1);
        chk("p1_c4099_wrap", o1(), 8'b001_00_1_1_1);
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
